// File: rtl/noc_packetizer.sv
// NoC packetizer: buffers core payload words in a small FIFO and emits multi-flit
// packets on a router port with per-packet VC allocation and credit flow control.
module noc_packetizer #(
   parameter  int DATA_W     = 64,
   parameter  int DEST_W     = 2,
   parameter  int NUM_VC     = 2,
   parameter  int CREDITS    = 4,
   parameter  int FIFO_DEPTH = 8,
   localparam int VC_W       = $clog2(NUM_VC),
   localparam int FLIT_W     = DATA_W + VC_W + DEST_W + 3
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_data_valid,
   input  logic              i_last,
   input  logic [DEST_W-1:0] i_dest,
   output logic              o_ready,
   output logic [FLIT_W-1:0] o_flit,
   output logic              o_flit_valid,
   input  logic              i_credit_valid,
   input  logic [VC_W-1:0]   i_credit_vc,
   output logic              o_credit_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [DATA_W-1:0]              r_mem_data [FIFO_DEPTH];
   logic [DEST_W-1:0]              r_mem_dest [FIFO_DEPTH];
   logic                           r_mem_last [FIFO_DEPTH];
   logic [AW-1:0]                  r_wptr, r_rptr;
   logic [AW:0]                    r_count;
   logic                           r_in_head;
   logic [DEST_W-1:0]              r_in_dest;
   logic [NUM_VC-1:0][CW-1:0]      r_cred;
   logic [VC_W-1:0]                r_rr, r_lock_vc;
   logic                           r_err;
   logic [FLIT_W-1:0]              r_flit;
   logic                           r_flit_valid;
   state_t                         r_state, w_next;

   logic                           w_wr, w_pop, w_empty, w_head, w_found;
   logic [VC_W-1:0]                w_vc, w_rr_vc, w_cand;
   logic [DEST_W-1:0]              w_in_dest;
   logic [NUM_VC-1:0]              w_inc, w_dec;

   assign o_ready      = (r_count != (AW+1)'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_wr         = i_data_valid & o_ready;
   // Body words inherit the dest latched from their head word.
   assign w_in_dest    = r_in_head ? i_dest : r_in_dest;
   assign o_flit       = r_flit;
   assign o_flit_valid = r_flit_valid;
   assign o_credit_err = r_err;

   always_ff @(posedge Clk) begin
      if (w_wr) begin
         r_mem_data[r_wptr] <= i_data;
         r_mem_dest[r_wptr] <= w_in_dest;
         r_mem_last[r_wptr] <= i_last;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_in_head <= 1'b1;
         r_in_dest <= '0;
      end else begin
         if (w_wr) begin
            r_wptr    <= r_wptr + AW'(1);
            r_in_head <= i_last;
            if (r_in_head) r_in_dest <= i_dest;
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Round-robin search; iterating downward lets the lowest offset from r_rr win.
   always_comb begin
      w_found = 1'b0;
      w_rr_vc = r_rr;
      w_cand  = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         w_cand = r_rr + VC_W'(i);
         if (r_cred[w_cand] != '0) begin
            w_found = 1'b1;
            w_rr_vc = w_cand;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_pop && !r_mem_last[r_rptr]) w_next = S_SEND;
         S_SEND:  if (w_pop &&  r_mem_last[r_rptr]) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop  = 1'b0;
      w_head = 1'b0;
      w_vc   = r_lock_vc;
      case (r_state)
         S_IDLE: if (!w_empty && w_found) begin
            w_pop  = 1'b1;
            w_head = 1'b1;
            w_vc   = w_rr_vc;
         end
         S_SEND: if (!w_empty && r_cred[r_lock_vc] != '0) w_pop = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_inc[v] = i_credit_valid && (i_credit_vc == VC_W'(v));
         w_dec[v] = w_pop && (w_vc == VC_W'(v));
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int v = 0; v < NUM_VC; v++) r_cred[v] <= CW'(CREDITS);
         r_err        <= 1'b0;
         r_rr         <= '0;
         r_lock_vc    <= '0;
         r_flit       <= '0;
         r_flit_valid <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (w_inc[v] && !w_dec[v]) begin
               if (r_cred[v] == CW'(CREDITS)) r_err <= 1'b1;
               else                          r_cred[v] <= r_cred[v] + CW'(1);
            end else if (w_dec[v] && !w_inc[v]) begin
               r_cred[v] <= r_cred[v] - CW'(1);
            end
         end
         if (w_pop && w_head) begin
            r_lock_vc <= w_vc;
            r_rr      <= w_vc + VC_W'(1);
         end
         if (w_pop)
            r_flit <= {1'b1, r_mem_last[r_rptr], r_mem_dest[r_rptr], w_vc, w_head,
                       r_mem_data[r_rptr]};
         r_flit_valid <= w_pop;
      end
   end

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed scenarios plus random traffic, all checked
// against a queue-based packet/credit model.
module tb_noc_packetizer;
   localparam int DATA_W = 64, DEST_W = 2, NUM_VC = 2, CREDITS = 4, FIFO_DEPTH = 8;
   localparam int VC_W = $clog2(NUM_VC);
   localparam int FLIT_W = DATA_W + VC_W + DEST_W + 3;

   logic              Clk = 1'b0, Rst_n = 1'b0;
   logic [DATA_W-1:0] i_data = '0;
   logic              i_data_valid = 1'b0, i_last = 1'b0;
   logic [DEST_W-1:0] i_dest = '0;
   logic              o_ready, o_flit_valid, o_credit_err;
   logic [FLIT_W-1:0] o_flit;
   logic              i_credit_valid = 1'b0;
   logic [VC_W-1:0]   i_credit_vc = '0;

   noc_packetizer #(.DATA_W(DATA_W), .DEST_W(DEST_W), .NUM_VC(NUM_VC), .CREDITS(CREDITS),
                    .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
      .i_last(i_last), .i_dest(i_dest), .o_ready(o_ready), .o_flit(o_flit),
      .o_flit_valid(o_flit_valid), .i_credit_valid(i_credit_valid),
      .i_credit_vc(i_credit_vc), .o_credit_err(o_credit_err));

   always #5 Clk = ~Clk;

   typedef struct { logic [DATA_W-1:0] d; logic [DEST_W-1:0] dest; logic last; } word_t;

   word_t             q[$];      // model FIFO contents
   word_t             pend[$];   // words waiting to be offered
   int                m_cred[NUM_VC];
   int                m_rr, m_lock;
   bit                m_inpkt, m_err, m_in_head, m_fv, m_acc, gate;
   logic [DEST_W-1:0] m_in_dest;
   logic [FLIT_W-1:0] m_flit;
   int                n_tot = 0, n_bad = 0, n_flits = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int v = 0; v < NUM_VC; v++) m_cred[v] = CREDITS;
      m_rr = 0; m_lock = 0; m_inpkt = 0; m_err = 0; m_in_head = 1;
      m_in_dest = '0; m_flit = '0; m_fv = 0; m_acc = 0;
   endtask

   // One clock edge of packet-level behaviour, evaluated on start-of-cycle state.
   task automatic model_step();
      int    sz = q.size();
      int    vc = -1;
      bit    hd = 0;
      bit    acc = i_data_valid && (sz < FIFO_DEPTH);
      word_t w;
      if (sz > 0) begin
         if (!m_inpkt) begin
            for (int i = 0; i < NUM_VC; i++)
               if (vc < 0 && m_cred[(m_rr + i) % NUM_VC] > 0) vc = (m_rr + i) % NUM_VC;
            hd = 1;
         end else if (m_cred[m_lock] > 0) vc = m_lock;
      end
      m_fv = 0;
      if (vc >= 0) begin
         w = q.pop_front();
         m_flit = {1'b1, w.last, w.dest, VC_W'(vc), hd, w.d};
         m_fv = 1;
         if (hd) begin m_rr = (vc + 1) % NUM_VC; m_lock = vc; end
         m_inpkt = !w.last;
      end
      for (int v = 0; v < NUM_VC; v++) begin
         int dec = (vc == v) ? 1 : 0;
         int inc = (i_credit_valid && i_credit_vc == VC_W'(v)) ? 1 : 0;
         if (inc == 1 && dec == 0 && m_cred[v] == CREDITS) m_err = 1;
         else m_cred[v] += inc - dec;
      end
      if (acc) begin
         q.push_back('{i_data, m_in_head ? i_dest : m_in_dest, i_last});
         if (m_in_head) m_in_dest = i_dest;
         m_in_head = i_last;
      end
      m_acc = acc;
   endtask

   task automatic cycle(input bit cv, input int cvc);
      @(negedge Clk);
      if (o_flit_valid) n_flits++;
      chk("ready", o_ready, q.size() < FIFO_DEPTH);
      chk("fvalid", o_flit_valid, m_fv);
      chk("flit", o_flit, m_flit);
      chk("err", o_credit_err, m_err);
      i_data_valid = (pend.size() > 0) && gate;
      if (pend.size() > 0) begin
         i_data = pend[0].d; i_dest = pend[0].dest; i_last = pend[0].last;
      end
      i_credit_valid = cv;
      i_credit_vc    = VC_W'(cvc);
      @(posedge Clk);
      model_step();
      if (m_acc) void'(pend.pop_front());
   endtask

   task automatic add_pkt(input int n, input int dest);
      for (int i = 0; i < n; i++)
         pend.push_back('{{$urandom, $urandom}, (i == 0) ? DEST_W'(dest) : DEST_W'($urandom),
                          i == n - 1});
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst_n = 1'b0;
      i_data_valid = 1'b0; i_credit_valid = 1'b0;
      #1;
      chk("rst_fv", o_flit_valid, 0);
      chk("rst_flit", o_flit, 0);
      chk("rst_err", o_credit_err, 0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      model_reset();
      pend.delete();
      n_flits = 0;
      gate = 1;
   endtask

   initial begin
      gate = 1;
      model_reset();
      do_reset();

      // single-word packet: head=tail=valid, VC0, dest 2, two cycles after acceptance
      pend.push_back('{64'hDEAD_BEEF, 2'b10, 1'b1});
      cycle(0, 0);
      cycle(0, 0);
      #1 chk("dbeef", o_flit, {1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 64'hDEAD_BEEF});
      chk("dbeef_v", o_flit_valid, 1);

      // three 4-word packets, no credit return: third stalls
      do_reset();
      add_pkt(4, 1); add_pkt(4, 2); add_pkt(4, 3);
      repeat (30) cycle(0, 0);
      chk("p2_stall", n_flits, 8);
      cycle(1, 0);
      repeat (5) cycle(0, 0);
      chk("p2_one", n_flits, 9);

      // drain credits, then fill FIFO with nothing able to leave
      do_reset();
      add_pkt(4, 0); add_pkt(4, 1);
      repeat (15) cycle(0, 0);
      add_pkt(3, 1); add_pkt(3, 2); add_pkt(3, 3);
      repeat (12) cycle(0, 0);
      #1 chk("full_rdy", o_ready, 0);
      chk("full_flits", n_flits, 8);
      for (int i = 0; i < 12; i++) cycle(1, i % 2);
      repeat (12) cycle(0, 0);
      chk("full_drain", n_flits, 17);

      // credit returned on VC0 in the same cycle a flit leaves at count 1
      do_reset();
      add_pkt(5, 0);
      repeat (4) cycle(0, 0);
      cycle(1, 0);
      repeat (4) cycle(0, 0);
      chk("same_cyc", n_flits, 5);

      // credit returned to a full counter
      do_reset();
      cycle(1, 1);
      #1 chk("err_set", o_credit_err, 1);
      repeat (3) cycle(0, 0);
      #1 chk("err_hold", o_credit_err, 1);

      // reset mid-packet, next packet restarts as head on VC0
      do_reset();
      add_pkt(4, 3);
      repeat (3) cycle(0, 0);
      do_reset();
      add_pkt(1, 1);
      cycle(0, 0);
      cycle(0, 0);
      #1 chk("rst_vc", o_flit[DATA_W+1], 0);
      chk("rst_head", o_flit[DATA_W], 1);
      chk("rst_dest", o_flit[DATA_W+2 +: DEST_W], 1);
      chk("rst_v", o_flit[FLIT_W-1], 1);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (pend.size() < 3) add_pkt($urandom_range(1, 5), $urandom_range(0, 3));
         gate = ($urandom_range(0, 9) < 7);
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, NUM_VC - 1));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
